// File: rtl/mop_dispatch_queue_pkg.sv
// Shared micro-op types for the cracker -> dispatch queue interface.
//   MAX_MOP_CNT  : largest number of micro-ops one instruction may crack into
//   micro_op_t   : one cracked micro-op as carried between cracker and rename
//   mopq_entry_t : a queued micro-op plus its instruction-boundary tags
package mop_dispatch_queue_pkg;

  localparam int MAX_MOP_CNT = 8;

  typedef enum logic [3:0] {
    MOP_NOP = 4'd0,
    MOP_LEA = 4'd1,
    MOP_LD  = 4'd2,
    MOP_ST  = 4'd3,
    MOP_ADD = 4'd4,
    MOP_SUB = 4'd5,
    MOP_CPY = 4'd6,
    MOP_BR  = 4'd7
  } mop_opcode_e;

  typedef struct packed {
    mop_opcode_e op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } micro_op_t;

  typedef struct packed {
    micro_op_t mop;
    logic      first;
    logic      last;
  } mopq_entry_t;

endpackage

// File: rtl/mopq_storage.sv
// Circular entry storage for the micro-op dispatch queue.
// Every entry decides on its own whether it falls inside the window
// [wr_base, wr_base + wr_cnt) (mod DEPTH), so a bundle of up to MAX_MOP_CNT
// micro-ops is written in one cycle and writes straddling DEPTH-1 wrap to 0.
// Ports:
//   clk      : clock (storage is data only, it has no reset)
//   wr_base  : queue index receiving bundle element 0
//   wr_cnt   : number of bundle elements to write (0 writes nothing)
//   wr_mops  : bundle micro-ops, index 0 oldest
//   rd_ptr   : read index (queue head)
//   rd_entry : entry at rd_ptr, combinational read
module mopq_storage
  import mop_dispatch_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int MAX_MOP_CNT = 8,
  parameter int CNT_W       = $clog2(MAX_MOP_CNT + 1),
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic [PTR_W-1:0]            wr_base,
  input  logic [CNT_W-1:0]            wr_cnt,
  input  micro_op_t [MAX_MOP_CNT-1:0] wr_mops,
  input  logic [PTR_W-1:0]            rd_ptr,
  output mopq_entry_t                 rd_entry
);

  localparam int IDX_W = (MAX_MOP_CNT > 1) ? $clog2(MAX_MOP_CNT) : 1;

  mopq_entry_t      mem     [DEPTH];
  mopq_entry_t      wr_data [DEPTH];
  logic [PTR_W-1:0] offset  [DEPTH];
  logic [DEPTH-1:0] wr_en;

  // offset is the bundle position that would land in entry j; only offsets
  // below wr_cnt are real, so the truncated mop select is harmless otherwise.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      offset[j]        = PTR_W'(j) - wr_base;
      wr_en[j]         = 32'(offset[j]) < 32'(wr_cnt);
      wr_data[j].mop   = wr_mops[offset[j][IDX_W-1:0]];
      wr_data[j].first = (offset[j] == '0);
      wr_data[j].last  = (32'(offset[j]) == (32'(wr_cnt) - 32'd1));
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (wr_en[j]) mem[j] <= wr_data[j];
    end
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/mop_dispatch_queue.sv
// Micro-op dispatch queue: accepts cracked instruction bundles from the
// cracker and issues their micro-ops one per cycle, in program order, to
// rename/issue. Error and oversize bundles are dropped and flagged.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : clear the queue on the next edge (redirect)
//   bundle_valid    : cracker presents a bundle
//   bundle_ready    : room for a worst-case bundle (registered)
//   bundle_cnt      : valid micro-ops in bundle_mops
//   bundle_err      : bundle is invalid and must be dropped
//   bundle_mops     : bundle micro-ops, index 0 oldest
//   mop_valid       : mop_out holds a micro-op
//   mop_ready       : downstream takes mop_out
//   mop_out         : head micro-op
//   mop_first/last  : head is first/last micro-op of its instruction
//   occupancy       : entries held
//   err_sticky      : an error/oversize bundle was dropped since reset
module mop_dispatch_queue
  import mop_dispatch_queue_pkg::*;
#(
  parameter int MAX_MOP_CNT = mop_dispatch_queue_pkg::MAX_MOP_CNT,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = $clog2(MAX_MOP_CNT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        bundle_valid,
  output logic                        bundle_ready,
  input  logic [CNT_W-1:0]            bundle_cnt,
  input  logic                        bundle_err,
  input  micro_op_t [MAX_MOP_CNT-1:0] bundle_mops,
  output logic                        mop_valid,
  input  logic                        mop_ready,
  output micro_op_t                   mop_out,
  output logic                        mop_first,
  output logic                        mop_last,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic                        err_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;
  logic             err_q;
  logic             rdy_q;

  logic             push;
  logic             bad;
  logic             pop;
  logic [CNT_W-1:0] wr_cnt;
  logic [OCC_W-1:0] occ_next;
  logic             rdy_next;
  mopq_entry_t      head_entry;

  always_comb begin
    push     = bundle_valid && rdy_q && !flush;
    bad      = bundle_err || (32'(bundle_cnt) > MAX_MOP_CNT);
    wr_cnt   = (push && !bad) ? bundle_cnt : '0;
    pop      = (occ_q != '0) && mop_ready && !flush;
    occ_next = occ_q + OCC_W'(wr_cnt) - OCC_W'(pop);
    // Ready is judged against a worst-case bundle so it never depends on
    // bundle_cnt; registering it keeps the cracker handshake loop-free.
    rdy_next = (DEPTH - 32'(occ_next)) >= MAX_MOP_CNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      rdy_q  <= 1'b1;
    end else begin
      head_q <= head_q + PTR_W'(pop);
      tail_q <= tail_q + PTR_W'(wr_cnt);
      occ_q  <= occ_next;
      rdy_q  <= rdy_next;
      if (push && bad) err_q <= 1'b1;
    end
  end

  mopq_storage #(
    .DEPTH      (DEPTH),
    .MAX_MOP_CNT(MAX_MOP_CNT),
    .CNT_W      (CNT_W),
    .PTR_W      (PTR_W)
  ) u_storage (
    .clk     (clk),
    .wr_base (tail_q),
    .wr_cnt  (wr_cnt),
    .wr_mops (bundle_mops),
    .rd_ptr  (head_q),
    .rd_entry(head_entry)
  );

  // Storage is never reset, so the head read is masked while empty to give
  // clean zero outputs after reset and flush.
  assign mop_valid    = (occ_q != '0);
  assign mop_out      = mop_valid ? head_entry.mop : '0;
  assign mop_first    = mop_valid && head_entry.first;
  assign mop_last     = mop_valid && head_entry.last;
  assign bundle_ready = rdy_q;
  assign occupancy    = occ_q;
  assign err_sticky   = err_q;

endmodule
